// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  // States in which the loader is willing to take a byte from the host.
  function automatic logic state_accepts(loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/prog_word_packer.sv
// Byte-in / 32-bit word-out packer, little-endian (first byte lands in bits [7:0]).
module prog_word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;
  logic        word_valid_q;

  assign last_byte_o  = (cnt_q == 2'(WORD_BYTES - 1));
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_valid_i && last_byte_o;
      if (byte_valid_i) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {byte_i, shift_q[23:8]};
        // word_q holds the last completed word so imem_wdata stays stable between strobes.
        if (last_byte_o) word_q <= {byte_i, shift_q};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: LEN header + little-endian words into imem, core held in reset until done.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int PROG_SIZE = 648,
  parameter int ADDR_W    = $clog2(PROG_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [LEN_W-1:0] PROG_SIZE_L = LEN_W'(PROG_SIZE);

  loader_state_t     state_q, state_d;
  logic              s_ready_q;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d, wl_inc;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              done_q, error_q, core_rst_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic accept, data_byte, last_byte, word_done;

  assign accept    = s_valid && s_ready_q;
  assign data_byte = accept && (state_q == DATA);
  assign word_done = data_byte && last_byte;
  assign wl_inc    = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};

  prog_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (data_byte),
    .byte_i       (s_data),
    .last_byte_o  (last_byte),
    .word_valid_o (imem_we),
    .word_o       (imem_wdata)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    len_lo_d       = len_lo_q;
    len_d          = len_q;
    words_loaded_d = words_loaded_q;
    imem_addr_d    = imem_addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d         = data_byte ? (csum_q ^ s_data) : csum_q;
`endif
    unique case (state_q)
      LEN_LO: if (accept) begin
        len_lo_d = s_data;
        state_d  = LEN_HI;
      end
      LEN_HI: if (accept) begin
        len_d   = {s_data, len_lo_q};
        state_d = ((len_d == '0) || (len_d > PROG_SIZE_L)) ? ERR : DATA;
      end
      DATA: if (word_done) begin
        // Address and count advance on the same edge that launches the write strobe.
        imem_addr_d    = words_loaded_q[ADDR_W-1:0];
        words_loaded_d = wl_inc;
        if (LEN_W'(wl_inc) == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
      CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept) state_d = (s_data == csum_q) ? DONE : ERR;
`else
        state_d = ERR;
`endif
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LEN_LO;
      s_ready_q      <= 1'b0;
      len_lo_q       <= '0;
      len_q          <= '0;
      words_loaded_q <= '0;
      imem_addr_q    <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      core_rst_q     <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      s_ready_q      <= state_accepts(state_d);
      len_lo_q       <= len_lo_d;
      len_q          <= len_d;
      words_loaded_q <= words_loaded_d;
      imem_addr_q    <= imem_addr_d;
      // Status lags the state by one cycle, so done never coincides with the final strobe.
      done_q         <= (state_q == DONE);
      error_q        <= (state_q == ERR);
      core_rst_q     <= (state_q != DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_addr    = imem_addr_q;
  assign words_loaded = words_loaded_q;
  assign done         = done_q;
  assign error        = error_q;
  assign core_rst     = core_rst_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: header table, scoreboarded imem writes, corner sequences.
module tb_prog_loader;

  localparam int PS = 648;
  localparam int AW = 10;

  logic          clk, rst, s_valid, s_ready, imem_we, core_rst, done, error;
  logic [7:0]    s_data;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  prog_loader #(.PROG_SIZE(PS)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] len;
    logic        exp_err;
  } len_vec_t;

  wr_t           sb_q[$];
  wr_t           mon_e;
  int            we_cyc[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            we_count = 0;
  logic [AW-1:0] exp_addr;
  logic [7:0]    tb_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every write strobe must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      we_count++;
      we_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("we_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("we_data", imem_wdata, mon_e.data);
      end
    end
  end

  task automatic do_reset();
    check("sb_drained", sb_q.size(), 0);
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    exp_addr = '0;
    tb_csum = '0;
  endtask

  // Leaves s_valid high at the negedge after acceptance so bytes can go back-to-back.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data = b;
    budget = 0;
    while (!s_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic send_len(input logic [15:0] len, input bit gaps);
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    sb_q.push_back('{addr: exp_addr, data: w});
    exp_addr = exp_addr + 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_csum = tb_csum ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], gaps);
    end
  endtask

  task automatic send_chk();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(tb_csum, 1'b0);
`endif
    s_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!done && !error && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 32'(done | error), 32'd1);
  endtask

  logic [31:0] t2_words [3];
  len_vec_t    vecs [5];
  int          we_base;

  initial begin
    t2_words[0] = 32'h0000_0013;
    t2_words[1] = 32'h0010_0093;
    t2_words[2] = 32'h0020_8133;
    vecs[0] = '{len: 16'h0000, exp_err: 1'b1};
    vecs[1] = '{len: 16'h0289, exp_err: 1'b1};
    vecs[2] = '{len: 16'hFFFF, exp_err: 1'b1};
    vecs[3] = '{len: 16'h0288, exp_err: 1'b0};
    vecs[4] = '{len: 16'h0001, exp_err: 1'b0};

    // Reset values while rst is held.
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    exp_addr = '0;
    tb_csum = '0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);

    // T1: single word, exact strobe/done timing.
    do_reset();
    send_len(16'd1, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    s_valid = 1'b0;
    check("t1_we_cycle", 32'(imem_we), 32'd1);
    check("t1_done_not_with_we", 32'(done), 32'd0);
    check("t1_core_rst_with_we", 32'(core_rst), 32'd1);
`ifndef PROG_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("t1_we_pulse", 32'(imem_we), 32'd0);
    check("t1_done_next", 32'(done), 32'd1);
    check("t1_core_rst_next", 32'(core_rst), 32'd0);
`else
    // T6 match case: T1 stream plus checksum 0x08.
    check("t6_csum_model", 32'(tb_csum), 32'h08);
    send_chk();
    wait_end();
`endif
    repeat (3) @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_core_rst", 32'(core_rst), 32'd0);
    check("t1_s_ready_low", 32'(s_ready), 32'd0);
    check("t1_words_loaded", 32'(words_loaded), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_we_count", we_count, 1);

    // T3 and header boundaries, table driven.
    we_base = we_count;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      send_len(vecs[i].len, 1'b0);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("len%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
      check($sformatf("len%0d_core_rst", i), 32'(core_rst), 32'd1);
      check($sformatf("len%0d_s_ready", i), 32'(s_ready), 32'(!vecs[i].exp_err));
      check($sformatf("len%0d_done", i), 32'(done), 32'd0);
    end
    check("t3_no_we", we_count, we_base);

    // T2: three words with s_valid held high; strobes 4 cycles apart.
    do_reset();
    we_base = we_count;
    we_cyc.delete();
    send_len(16'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(t2_words[i], 1'b0);
    send_chk();
    wait_end();
    @(negedge clk);
    check("t2_we_count", we_count - we_base, 3);
    if (we_cyc.size() == 3) begin
      check("t2_spacing01", we_cyc[1] - we_cyc[0], 4);
      check("t2_spacing12", we_cyc[2] - we_cyc[1], 4);
    end else begin
      check("t2_we_cyc_size", we_cyc.size(), 3);
    end
    check("t2_words_loaded", 32'(words_loaded), 32'd3);
    check("t2_done", 32'(done), 32'd1);
    check("t2_error", 32'(error), 32'd0);

    // T4: same stream with random s_valid gaps.
    do_reset();
    we_base = we_count;
    send_len(16'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_word(t2_words[i], 1'b1);
    send_chk();
    wait_end();
    repeat (2) @(negedge clk);
    check("t4_we_count", we_count - we_base, 3);
    check("t4_words_loaded", 32'(words_loaded), 32'd3);
    check("t4_done", 32'(done), 32'd1);
    check("t4_core_rst", 32'(core_rst), 32'd0);

    // T5: abort after six data bytes, then the T1 stream.
    do_reset();
    send_len(16'd3, 1'b0);
    send_word(t2_words[0], 1'b0);
    send_byte(t2_words[1][7:0], 1'b0);
    send_byte(t2_words[1][15:8], 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    do_reset();
    we_base = we_count;
    send_len(16'd1, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    send_chk();
    wait_end();
    repeat (2) @(negedge clk);
    check("t5_we_count", we_count - we_base, 1);
    check("t5_words_loaded", 32'(words_loaded), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_wdata_held", imem_wdata, 32'h1234_5678);

`ifdef PROG_LOADER_CHECKSUM_EN
    // T6 mismatch case: bad checksum still writes the word, then errors.
    do_reset();
    we_base = we_count;
    send_len(16'd1, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    send_byte(8'h09, 1'b0);
    s_valid = 1'b0;
    wait_end();
    repeat (2) @(negedge clk);
    check("t6_error", 32'(error), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_core_rst", 32'(core_rst), 32'd1);
    check("t6_word_written", we_count - we_base, 1);
`endif

    check("final_sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
